alu_operand_regfile: RTL and testbench

- 32-entry x 64-bit register file directly upstream of the 64-bit ALU; drives its A and B operand inputs.
- Adds a 4-bit status-flag register that captures the ALU's 4-bit status output and feeds the carry back as the ALU carry-in.
- Two registered read ports, one write port, write-to-read bypass, hardwired zero register.

---
 rtl/alu_operand_regfile.sv | 84 ++++++++
 tb/tb_alu_operand_regfile.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/alu_operand_regfile.sv
// Operand register file feeding the 64-bit ALU: two registered read ports with
// write-through bypass, one write port, hardwired zero register and a status-flag register.
module alu_operand_regfile #(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned ZERO_REG = 31
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              flag_we,
   input  logic [3:0]        flag_in,
   output logic [3:0]        flags,
   output logic              carry_out
);

   localparam int unsigned       DEPTH     = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_a_q, rd_a_d;
   logic [DATA_W-1:0] rd_b_q, rd_b_d;
   logic [3:0]        flags_q;
   logic              wr_valid;

   // The zero register is never stored, so a write to it has no effect anywhere.
   assign wr_valid = wr_en && (wr_addr != ZERO_ADDR);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_valid) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Zero register wins over bypass; bypass wins over the stored value.
   always_comb begin
      rd_a_d = mem_q[rd_addr_a];
      if (rd_addr_a == ZERO_ADDR) begin
         rd_a_d = '0;
      end else if (wr_valid && (wr_addr == rd_addr_a)) begin
         rd_a_d = wr_data;
      end
   end

   always_comb begin
      rd_b_d = mem_q[rd_addr_b];
      if (rd_addr_b == ZERO_ADDR) begin
         rd_b_d = '0;
      end else if (wr_valid && (wr_addr == rd_addr_b)) begin
         rd_b_d = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_a_q  <= '0;
         rd_b_q  <= '0;
         flags_q <= 4'b0000;
      end else begin
         rd_a_q <= rd_a_d;
         rd_b_q <= rd_b_d;
         if (flag_we) begin
            flags_q <= flag_in;
         end
      end
   end

   assign rd_data_a = rd_a_q;
   assign rd_data_b = rd_b_q;
   assign flags     = flags_q;
   // Flags are {N,Z,C,V}; only the registered C feeds back as carry-in.
   assign carry_out = flags_q[1];

endmodule

// File: tb/tb_alu_operand_regfile.sv
// Directed bench for alu_operand_regfile: vector table plus a full write/read sweep.
module tb_alu_operand_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [63:0] wr_data;
   logic [4:0]  rd_addr_a;
   logic [4:0]  rd_addr_b;
   logic [63:0] rd_data_a;
   logic [63:0] rd_data_b;
   logic        flag_we;
   logic [3:0]  flag_in;
   logic [3:0]  flags;
   logic        carry_out;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alu_operand_regfile dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b),
      .flag_we   (flag_we),
      .flag_in   (flag_in),
      .flags     (flags),
      .carry_out (carry_out)
   );

   typedef struct {
      logic        rst;
      logic        wr_en;
      logic [4:0]  wr_addr;
      logic [63:0] wr_data;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic        flag_we;
      logic [3:0]  flag_in;
      logic [63:0] exp_a;
      logic [63:0] exp_b;
      logic [3:0]  exp_flags;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic we, input logic [4:0] wa, input logic [63:0] wd,
                      input logic [4:0] ra, input logic [4:0] rb, input logic fwe,
                      input logic [3:0] fin, input logic [63:0] ea, input logic [63:0] eb,
                      input logic [3:0] ef);
      vec_t v;
      v = '{r, we, wa, wd, ra, rb, fwe, fin, ea, eb, ef};
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      @(negedge clk);
      rst       = v.rst;
      wr_en     = v.wr_en;
      wr_addr   = v.wr_addr;
      wr_data   = v.wr_data;
      rd_addr_a = v.ra;
      rd_addr_b = v.rb;
      flag_we   = v.flag_we;
      flag_in   = v.flag_in;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] pat(input int i);
      return 64'h0123_4567_89AB_CDEF ^ (64'(i) * 64'h0101_0101_0101_0101);
   endfunction

   initial begin
      vec_t v;
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr_a = '0; rd_addr_b = '0; flag_we = 1'b0; flag_in = '0;

      //  rst we  wa  wd                      ra  rb fwe fin     exp_a                   exp_b   flags
      add(1, 0, 0,  64'd0,                    0,  0, 0, 4'h0,   64'd0,                  64'd0,  4'h0);
      add(0, 1, 3,  64'd205,                  0,  0, 0, 4'h0,   64'd0,                  64'd0,  4'h0);
      add(0, 0, 0,  64'd0,                    3,  0, 0, 4'h0,   64'd205,                64'd0,  4'h0);
      add(1, 0, 0,  64'd0,                    3,  3, 0, 4'h0,   64'd0,                  64'd0,  4'h0);
      add(0, 0, 0,  64'd0,                    3,  3, 0, 4'h0,   64'd0,                  64'd0,  4'h0);
      add(0, 1, 1,  64'd205,                  0,  0, 0, 4'h0,   64'd0,                  64'd0,  4'h0);
      add(0, 1, 2,  64'd512,                  0,  0, 0, 4'h0,   64'd0,                  64'd0,  4'h0);
      add(0, 0, 0,  64'd0,                    1,  2, 0, 4'h0,   64'd205,                64'd512, 4'h0);
      add(0, 1, 7,  64'h1111,                 0,  0, 0, 4'h0,   64'd0,                  64'd0,  4'h0);
      add(0, 1, 7,  64'hDEAD_BEEF_0000_0001,  7,  7, 0, 4'h0,   64'hDEAD_BEEF_0000_0001,
          64'hDEAD_BEEF_0000_0001, 4'h0);
      add(0, 0, 0,  64'd0,                    7,  7, 0, 4'h0,   64'hDEAD_BEEF_0000_0001,
          64'hDEAD_BEEF_0000_0001, 4'h0);
      add(0, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF,  31, 31, 0, 4'h0,  64'd0,                  64'd0,  4'h0);
      add(0, 0, 0,  64'd0,                    31, 31, 0, 4'h0,  64'd0,                  64'd0,  4'h0);
      add(0, 0, 0,  64'd0,                    0,  0, 1, 4'b0010, 64'd0,                 64'd0,  4'b0010);
      add(0, 0, 0,  64'd0,                    0,  0, 0, 4'b1101, 64'd0,                 64'd0,  4'b0010);
      add(0, 0, 0,  64'd0,                    0,  0, 0, 4'b1101, 64'd0,                 64'd0,  4'b0010);
      add(0, 0, 0,  64'd0,                    0,  0, 0, 4'b1101, 64'd0,                 64'd0,  4'b0010);
      add(0, 0, 0,  64'd0,                    0,  0, 1, 4'b1101, 64'd0,                 64'd0,  4'b1101);
      add(0, 1, 4,  64'd77,                   4,  1, 0, 4'h0,   64'd77,                 64'd205, 4'b1101);
      add(1, 1, 4,  64'd99,                   4,  4, 1, 4'hF,   64'd0,                  64'd0,  4'h0);
      add(0, 0, 0,  64'd0,                    4,  1, 0, 4'h0,   64'd0,                  64'd0,  4'h0);
      add(0, 1, 1,  64'hA1,                   0,  0, 0, 4'h0,   64'd0,                  64'd0,  4'h0);
      add(0, 1, 5,  64'h55,                   5,  1, 1, 4'b1010, 64'h55,                64'hA1, 4'b1010);

      foreach (vecs[i]) begin
         drive(vecs[i]);
         chk($sformatf("vec%0d rd_data_a", i), rd_data_a, vecs[i].exp_a);
         chk($sformatf("vec%0d rd_data_b", i), rd_data_b, vecs[i].exp_b);
         chk($sformatf("vec%0d flags", i), 64'(flags), 64'(vecs[i].exp_flags));
         chk($sformatf("vec%0d carry_out", i), 64'(carry_out), 64'(vecs[i].exp_flags[1]));
      end

      // Sweep: fill every register, then read each back on A with its neighbour on B.
      for (int i = 0; i < 32; i++) begin
         v = '{0, 1, 5'(i), pat(i), 5'd0, 5'd0, 0, 4'h0, 64'd0, 64'd0, 4'b1010};
         drive(v);
      end
      for (int i = 0; i < 32; i++) begin
         int j;
         logic [63:0] ea, eb;
         j  = (i + 1) % 32;
         ea = (i == 31) ? 64'd0 : pat(i);
         eb = (j == 31) ? 64'd0 : pat(j);
         v  = '{0, 0, 5'd0, 64'd0, 5'(i), 5'(j), 0, 4'h0, 64'd0, 64'd0, 4'b1010};
         drive(v);
         chk($sformatf("sweep%0d rd_data_a", i), rd_data_a, ea);
         chk($sformatf("sweep%0d rd_data_b", i), rd_data_b, eb);
      end
      chk("sweep flags held", 64'(flags), 64'(4'b1010));
      chk("sweep carry_out", 64'(carry_out), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
